// File: rtl/majority_window_filter_pkg.sv
// Shared definitions for the majority window filter: FSM encoding,
// legal window-size bounds and the majority/hysteresis decision helper.
package majority_window_filter_pkg;

  localparam int MAJ_N_MIN = 32'sd2;
  localparam int MAJ_N_MAX = 32'sd32;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

  // Majority with tie hysteresis: on an exact half the previous decision is kept.
  function automatic logic maj_decide(input int ones, input int n, input logic prev);
    logic res;
    if ((32'sd2 * ones) > n) begin
      res = 1'b1;
    end else if ((32'sd2 * ones) < n) begin
      res = 1'b0;
    end else begin
      res = prev;
    end
    return res;
  endfunction

endpackage

// File: rtl/majority_window_shreg.sv
// N-sample shift register with an incrementally maintained ones counter.
// Newest sample enters at bit 0; the bit leaving at N-1 is subtracted.
module majority_window_shreg
  import majority_window_filter_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             din_i,
  output logic [N-1:0]     window_o,
  output logic [CNT_W-1:0] ones_o,
  output logic [CNT_W-1:0] ones_next_o
);

  logic [N-1:0]     window_q;
  logic [N-1:0]     window_d;
  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] ones_d;
  logic             out_bit_s;

  assign out_bit_s = window_q[N-1];

  // Next window and count; exact because the window always starts zeroed.
  always_comb begin
    window_d = {window_q[N-2:0], din_i};
    ones_d   = ones_q + {{(CNT_W-1){1'b0}}, din_i} - {{(CNT_W-1){1'b0}}, out_bit_s};
  end

  // Window and counter update only on sample strobes; flush on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      ones_q   <= '0;
    end else if (clear_i) begin
      window_q <= '0;
      ones_q   <= '0;
    end else if (shift_i) begin
      window_q <= window_d;
      ones_q   <= ones_d;
    end else begin
      window_q <= window_q;
      ones_q   <= ones_q;
    end
  end

  assign window_o    = window_q;
  assign ones_o      = ones_q;
  assign ones_next_o = ones_d;

endmodule

// File: rtl/majority_window_filter.sv
// Sliding-window majority filter: collects a serial bit into an N-sample
// window, exposes the window, and produces a registered majority decision
// with tie hysteresis plus a one-cycle change pulse.
module majority_window_filter
  import majority_window_filter_pkg::*;
#(
  parameter  int N     = 4,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             din,
  output logic [N-1:0]     window,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             filling,
  output logic             dout,
  output logic             dout_valid,
  output logic             dout_change
);

  generate
    if ((N < MAJ_N_MIN) || (N > MAJ_N_MAX)) begin : g_bad_n
      $error("majority_window_filter: N must be within 2..32");
    end
  endgenerate

  fsm_state_e       state_q;
  logic [CNT_W-1:0] fill_cnt_q;
  logic             filling_q;
  logic             dout_q;
  logic             dout_d;
  logic             dout_valid_q;
  logic             dout_change_q;
  logic             fill_done_s;
  logic [CNT_W-1:0] ones_next_s;

  majority_window_shreg #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .shift_i     (sample_en),
    .din_i       (din),
    .window_o    (window),
    .ones_o      (ones_cnt),
    .ones_next_o (ones_next_s)
  );

  // Decision on the post-update count; last sample of the fill completes the window.
  always_comb begin
    dout_d      = maj_decide(int'(ones_next_s), N, dout_q);
    fill_done_s = (fill_cnt_q == CNT_W'(N - 1));
  end

  // Fill/run sequencing with registered decision, valid and change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      fill_cnt_q    <= '0;
      filling_q     <= 1'b1;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      dout_change_q <= 1'b0;
    end else if (clear) begin
      state_q       <= ST_FILL;
      fill_cnt_q    <= '0;
      filling_q     <= 1'b1;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      dout_change_q <= 1'b0;
    end else if (sample_en) begin
      case (state_q)
        ST_FILL: begin
          dout_change_q <= 1'b0;
          if (fill_done_s) begin
            state_q      <= ST_RUN;
            fill_cnt_q   <= CNT_W'(N);
            filling_q    <= 1'b0;
            dout_valid_q <= 1'b1;
            dout_q       <= dout_d;
          end else begin
            fill_cnt_q   <= fill_cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          dout_q        <= dout_d;
          dout_change_q <= (dout_d != dout_q);
        end
        default: begin
          state_q       <= ST_FILL;
          fill_cnt_q    <= '0;
          filling_q     <= 1'b1;
          dout_q        <= 1'b0;
          dout_valid_q  <= 1'b0;
          dout_change_q <= 1'b0;
        end
      endcase
    end else begin
      dout_change_q <= 1'b0;
    end
  end

  assign filling     = filling_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign dout_change = dout_change_q;

endmodule

// File: tb/tb_majority_window_filter.sv
// Scoreboard bench for majority_window_filter with an N=4 and an N=5 instance.
module tb_majority_window_filter;

  typedef struct packed {
    logic [31:0] win;
    logic [7:0]  fill;
    logic        dout;
    logic        valid;
    logic        change;
  } mdl_t;

  typedef struct packed {
    logic [31:0] win;
    logic [5:0]  ones;
    logic        filling;
    logic        dout;
    logic        valid;
    logic        change;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr4 = 1'b0, en4 = 1'b0, d4 = 1'b0;
  logic clr5 = 1'b0, en5 = 1'b0, d5 = 1'b0;
  logic [3:0] win4;
  logic [2:0] ones4;
  logic fill4, dout4, val4, chg4;
  logic [4:0] win5;
  logic [2:0] ones5;
  logic fill5, dout5, val5, chg5;

  int n_vec = 0;
  int n_err = 0;
  mdl_t m4, m5;
  exp_t q4[$];
  exp_t q5[$];
  exp_t e;

  always #5 clk = ~clk;

  majority_window_filter #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clr4), .sample_en(en4), .din(d4),
    .window(win4), .ones_cnt(ones4), .filling(fill4), .dout(dout4),
    .dout_valid(val4), .dout_change(chg4)
  );

  majority_window_filter #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clear(clr5), .sample_en(en5), .din(d5),
    .window(win5), .ones_cnt(ones5), .filling(fill5), .dout(dout5),
    .dout_valid(val5), .dout_change(chg5)
  );

  // Reference model: recomputes the window from scratch, counts by popcount.
  function automatic mdl_t mstep(mdl_t m, int n, logic c, logic en, logic d);
    mdl_t r;
    logic [31:0] mask;
    int ones;
    logic nd;
    r = m;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    if (c) begin
      r = '0;
    end else if (en) begin
      r.win = ((m.win << 1) | {31'd0, d}) & mask;
      ones = $countones(r.win);
      if (2 * ones > n) nd = 1'b1;
      else if (2 * ones < n) nd = 1'b0;
      else nd = m.dout;
      r.change = 1'b0;
      if (m.valid) begin
        r.change = (nd != m.dout);
        r.dout   = nd;
      end else begin
        r.fill = m.fill + 8'd1;
        if (int'(r.fill) == n) begin
          r.valid = 1'b1;
          r.dout  = nd;
        end
      end
    end else begin
      r.change = 1'b0;
    end
    return r;
  endfunction

  function automatic exp_t mexp(mdl_t m);
    exp_t x;
    x.win     = m.win;
    x.ones    = 6'($countones(m.win));
    x.filling = ~m.valid;
    x.dout    = m.dout;
    x.valid   = m.valid;
    x.change  = m.change;
    return x;
  endfunction

  function automatic exp_t obs4();
    return {28'd0, win4, 3'd0, ones4, fill4, dout4, val4, chg4};
  endfunction

  function automatic exp_t obs5();
    return {27'd0, win5, 3'd0, ones5, fill5, dout5, val5, chg5};
  endfunction

  // Drive one cycle on the N=4 instance from a falling edge and queue the expectation.
  task automatic step4(input logic c, input logic en, input logic d);
    clr4 = c; en4 = en; d4 = d;
    m4 = mstep(m4, 4, c, en, d);
    q4.push_back(mexp(m4));
    @(posedge clk);
    @(negedge clk);
    clr4 = 1'b0; en4 = 1'b0;
  endtask

  task automatic step5(input logic c, input logic en, input logic d);
    clr5 = c; en5 = en; d5 = d;
    m5 = mstep(m5, 5, c, en, d);
    q5.push_back(mexp(m5));
    @(posedge clk);
    @(negedge clk);
    clr5 = 1'b0; en5 = 1'b0;
  endtask

  task automatic test_reset();
    m4 = '0; m5 = '0;
    repeat (2) @(negedge clk);
    e = mexp(m4);
    n_vec++;
    if (obs4() !== e) begin n_err++; $display("FAIL reset4: got %h expected %h", obs4(), e); end
    e = mexp(m5);
    n_vec++;
    if (obs5() !== e) begin n_err++; $display("FAIL reset5: got %h expected %h", obs5(), e); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      step4(1'b0, 1'b1, 1'b1);
      e = q4.pop_front();
      n_vec++;
      if (obs4() !== e) begin n_err++; $display("FAIL fill[%0d]: got %h expected %h", i, obs4(), e); end
    end
    n_vec++;
    if ({win4, ones4, val4, dout4, chg4} !== {4'b1111, 3'd4, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL fill_done: got %b expected 1111_100_1_1_0", {win4, ones4, val4, dout4, chg4});
    end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 3; i++) begin
      step4(1'b0, 1'b1, 1'b0);
      e = q4.pop_front();
      n_vec++;
      if (obs4() !== e) begin n_err++; $display("FAIL hyst[%0d]: got %h expected %h", i, obs4(), e); end
      if (i == 1) begin
        n_vec++;
        if ({dout4, chg4} !== 2'b10) begin n_err++; $display("FAIL tie_hold: got %b expected 10", {dout4, chg4}); end
      end
    end
    n_vec++;
    if ({win4, dout4, chg4} !== 6'b1000_0_1) begin
      n_err++; $display("FAIL drop: got %b expected 100001", {win4, dout4, chg4});
    end
    step4(1'b0, 1'b0, 1'b1);
    e = q4.pop_front();
    n_vec++;
    if (obs4() !== e) begin n_err++; $display("FAIL pulse_end: got %h expected %h", obs4(), e); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      step4(1'b0, 1'b0, i[0]);
      e = q4.pop_front();
      n_vec++;
      if (obs4() !== e) begin n_err++; $display("FAIL hold[%0d]: got %h expected %h", i, obs4(), e); end
    end
  endtask

  task automatic test_clear();
    step4(1'b1, 1'b1, 1'b1);
    e = q4.pop_front();
    n_vec++;
    if (obs4() !== e) begin n_err++; $display("FAIL clear: got %h expected %h", obs4(), e); end
    for (int i = 0; i < 4; i++) begin
      step4(1'b0, 1'b1, 1'b1);
      e = q4.pop_front();
      n_vec++;
      if (obs4() !== e) begin n_err++; $display("FAIL refill[%0d]: got %h expected %h", i, obs4(), e); end
    end
  endtask

  task automatic test_async_reset();
    exp_t z;
    m4 = '0; m5 = '0;
    z = mexp(m4);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs4() !== z) begin n_err++; $display("FAIL async_rst: got %h expected %h", obs4(), z); end
    en4 = 1'b1; d4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (obs4() !== z) begin n_err++; $display("FAIL rst_hold[%0d]: got %h expected %h", i, obs4(), z); end
    end
    en4 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_odd_n();
    logic [5:0] pat;
    pat = 6'b110100;
    for (int i = 0; i < 6; i++) begin
      step5(1'b0, 1'b1, pat[5 - i]);
      e = q5.pop_front();
      n_vec++;
      if (obs5() !== e) begin n_err++; $display("FAIL odd[%0d]: got %h expected %h", i, obs5(), e); end
      if (i == 4) begin
        n_vec++;
        if ({win5, ones5, dout5, val5} !== {5'b11010, 3'd3, 1'b1, 1'b1}) begin
          n_err++; $display("FAIL odd_full: got %b expected 11010_011_1_1", {win5, ones5, dout5, val5});
        end
      end
    end
    n_vec++;
    if ({win5, ones5, dout5, chg5} !== {5'b10100, 3'd2, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL odd_drop: got %b expected 10100_010_0_1", {win5, ones5, dout5, chg5});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      step4(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      e = q4.pop_front();
      n_vec++;
      if (obs4() !== e) begin n_err++; $display("FAIL b2b4[%0d]: got %h expected %h", i, obs4(), e); end
      step5(($urandom_range(0, 19) == 0), 1'b1, 1'($urandom_range(0, 1)));
      e = q5.pop_front();
      n_vec++;
      if (obs5() !== e) begin n_err++; $display("FAIL b2b5[%0d]: got %h expected %h", i, obs5(), e); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hysteresis();
    test_hold();
    test_clear();
    test_async_reset();
    test_odd_n();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/majority_window_filter.md
Name: majority_window_filter

Overview:
Sequential front-end for the majority_n_bit voter. It collects a serial input into an N-sample sliding window, one sample per strobe. It exposes the window as a parallel vector for a downstream majority_n_bit instance. It also produces its own registered, glitch-free majority decision with tie hysteresis and a change pulse. Typical use is de-noising a sampled control or sensor bit before it reaches consuming logic.

Parameters:
N, 4, window width in samples; legal range 2..32.
CNT_W, $clog2(N+1), width of the ones counter; derived, never overridden.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous window flush; returns the block to the reset state on the next edge.
sample_en  input  1  sample strobe; din is captured on an edge where this is 1.
din  input  1  serial input bit.
window  output  N  sample window, newest sample in bit 0; drives a of majority_n_bit.
ones_cnt  output  CNT_W  number of 1s in window.
filling  output  1  1 while fewer than N samples have been taken since reset or clear.
dout  output  1  registered majority decision.
dout_valid  output  1  1 once the window holds N samples.
dout_change  output  1  one-cycle pulse when dout toggles while valid.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - window=0, ones_cnt=0, dout=0, dout_valid=0, dout_change=0.
  - State=FILL, so filling=1; fill counter=0.
- clear=1 at an edge: same values as reset, synchronous. clear has priority over a simultaneous sample_en.
- Sample edge (sample_en=1, clear=0):
  - window <= {window[N-2:0], din}.
  - ones_cnt <= ones_cnt + din - window[N-1]. This incremental form is exact because the window starts zeroed.
  - ones_cnt never exceeds N and never underflows.
- No sample (sample_en=0): every register holds; dout_change=0.
- State machine:
  - FILL: fill counter increments per sample. When the sample that makes the count reach N is taken, go to RUN, set dout_valid=1, and drop filling on that same edge.
  - RUN: stays in RUN until reset or clear. The fill counter saturates and is not used.
- Decision: let ones_next be the post-update count, evaluated at every sample edge that ends in RUN, including the FILL->RUN edge.
  - 2*ones_next > N: dout <= 1.
  - 2*ones_next < N: dout <= 0.
  - 2*ones_next == N (even N only): dout holds its previous value. This is the tie hysteresis.
- In FILL, dout stays 0 and is not evaluated.
- Latency: dout reflects the window including the sample taken at the same edge, so it is visible one cycle after the sample_en cycle.
- dout_change = 1 for exactly one cycle after an edge where dout_valid was already 1 and dout toggled. The FILL->RUN edge never pulses, even if dout becomes 1.
- Back-to-back sample_en (every cycle) is fully supported; there is no throughput limit.
- Reset or clear mid-window discards all samples; refill takes N more strobes.
- window changes only on sample edges, so a downstream combinational voter sees a stable vector between strobes.

Decomposition:
- Shared include file: state encodings (ST_FILL, ST_RUN) and the N legality bounds (MAJ_N_MIN=2, MAJ_N_MAX=32), with an elaboration-time check.
- One natural sub-module: majority_window_shreg, holding the N-bit shift register, its outgoing bit and the incremental ones counter.
- The FSM and decision/hysteresis logic stay in the top module.

Test Plan:
1. N=4, after reset, four sample_en cycles with din=1. After samples 1-3: dout_valid=0, filling=1, dout=0, ones_cnt=1,2,3. After sample 4: window=4'b1111, ones_cnt=4, dout_valid=1, dout=1, dout_change=0.
2. N=4, from window=4'b1111, sample din=0 three times:
   - window=1110, ones_cnt=3, dout=1.
   - window=1100, ones_cnt=2, tie, dout stays 1, no pulse.
   - window=1000, ones_cnt=1, dout=0, dout_change=1 for one cycle only.
3. N=4 in RUN, sample_en=0 for 10 cycles while din toggles every cycle: window, ones_cnt, dout constant; dout_change=0 throughout.
4. N=4 in RUN, clear=1 and sample_en=1 with din=1 on the same edge: window=0, ones_cnt=0, dout=0, dout_valid=0, filling=1. Refill requires 4 new samples.
5. N=4 in RUN with dout=1, rst_n pulsed low between clock edges: all outputs zero before the next rising edge. Holding rst_n low across edges with sample_en=1 changes nothing.
6. N=5, samples 1,1,0,1,0 then 0:
   - After the 5th sample: window=5'b11010, ones_cnt=3, dout=1, dout_valid=1.
   - After the 6th sample: window=10100, ones_cnt=2, dout=0, dout_change pulses.
   - No tie case is ever reached with odd N.
